// File: rtl/if_id_stage.sv
// PC register and IF/ID pipeline register with flush/stall handling.
// Optional performance counters enabled by defining IF_ID_PERF_CNT_EN.
module if_id_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            PCWrite_i,
  input  logic            IF_ID_Write_i,
  input  logic            Flush_i,
  input  logic [XLEN-1:0] Branch_target_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] IF_ID_pc_o,
  output logic [XLEN-1:0] IF_ID_instr_o,
  output logic            IF_ID_valid_o,
  output logic [31:0]     stall_cycles_o,
  output logic [31:0]     flush_count_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;
  logic            if_valid_q;
  logic            running;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start_i) state_d = RUN;
  end

  assign running = (state_q == RUN);

  // Flush wins over any combination of write enables.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else if (running) begin
      if (Flush_i) begin
        pc_q       <= Branch_target_i;
        if_pc_q    <= '0;
        if_instr_q <= NOP_INSTR;
        if_valid_q <= 1'b0;
      end else begin
        if (PCWrite_i) pc_q <= pc_q + XLEN'(4);
        if (IF_ID_Write_i) begin
          if_pc_q    <= pc_q;
          if_instr_q <= instr_i;
          if_valid_q <= 1'b1;
        end
      end
    end
  end

  assign pc_o          = pc_q;
  assign IF_ID_pc_o    = if_pc_q;
  assign IF_ID_instr_o = if_instr_q;
  assign IF_ID_valid_o = if_valid_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (running) begin
      if (Flush_i && flush_q != '1) flush_q <= flush_q + 32'd1;
      if (!Flush_i && !PCWrite_i && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, async reset sequence,
// then random traffic against a behavioural model.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, PCWrite_i, IF_ID_Write_i, Flush_i;
  logic [31:0] Branch_target_i, instr_i;
  logic [31:0] pc_o, IF_ID_pc_o, IF_ID_instr_o;
  logic        IF_ID_valid_o;
  logic [31:0] stall_cycles_o, flush_count_o;

  int checks = 0;
  int errors = 0;

  if_id_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .PCWrite_i(PCWrite_i),
    .IF_ID_Write_i(IF_ID_Write_i), .Flush_i(Flush_i),
    .Branch_target_i(Branch_target_i), .instr_i(instr_i), .pc_o(pc_o),
    .IF_ID_pc_o(IF_ID_pc_o), .IF_ID_instr_o(IF_ID_instr_o),
    .IF_ID_valid_o(IF_ID_valid_o), .stall_cycles_o(stall_cycles_o),
    .flush_count_o(flush_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start, pcw, ifw, flush;
    logic [31:0] target, instr;
    logic [31:0] e_pc, e_ifpc, e_instr;
    logic        e_valid;
    logic [31:0] e_stall, e_flush;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic s, logic pw, logic iw, logic fl, logic [31:0] tg,
                              logic [31:0] in, logic [31:0] pc, logic [31:0] ipc,
                              logic [31:0] iin, logic v, logic [31:0] sc, logic [31:0] fc);
    vec_t r;
    r.start = s; r.pcw = pw; r.ifw = iw; r.flush = fl; r.target = tg; r.instr = in;
    r.e_pc = pc; r.e_ifpc = ipc; r.e_instr = iin; r.e_valid = v;
    r.e_stall = PERF ? sc : 32'd0;
    r.e_flush = PERF ? fc : 32'd0;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [31:0] pc, logic [31:0] ipc, logic [31:0] iin,
                           logic v, logic [31:0] sc, logic [31:0] fc);
    check({tag, " pc_o"}, pc_o, pc);
    check({tag, " IF_ID_pc_o"}, IF_ID_pc_o, ipc);
    check({tag, " IF_ID_instr_o"}, IF_ID_instr_o, iin);
    check({tag, " IF_ID_valid_o"}, {31'd0, IF_ID_valid_o}, {31'd0, v});
    check({tag, " stall_cycles_o"}, stall_cycles_o, sc);
    check({tag, " flush_count_o"}, flush_count_o, fc);
  endtask

  task automatic drive(logic s, logic pw, logic iw, logic fl, logic [31:0] tg, logic [31:0] in);
    start_i = s; PCWrite_i = pw; IF_ID_Write_i = iw; Flush_i = fl;
    Branch_target_i = tg; instr_i = in;
  endtask

  // behavioural model
  bit          m_run;
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid;
  longint      m_stall, m_flush;

  function automatic logic [31:0] sat(longint v);
    return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  initial begin
    tbl[0]  = mk(0,1,1,0,0,          32'h0,       32'h0,        0,           NOP,          0, 0, 0);
    tbl[1]  = mk(0,0,0,0,0,          32'h0,       32'h0,        0,           NOP,          0, 0, 0);
    tbl[2]  = mk(0,1,1,1,32'h100,    32'hDEAD,    32'h0,        0,           NOP,          0, 0, 0);
    tbl[3]  = mk(1,1,1,0,0,          32'hBEEF,    32'h0,        0,           NOP,          0, 0, 0);
    tbl[4]  = mk(0,1,1,0,0,          32'h00500093,32'h4,        0,           32'h00500093, 1, 0, 0);
    tbl[5]  = mk(0,1,1,0,0,          32'h11111111,32'h8,        32'h4,       32'h11111111, 1, 0, 0);
    tbl[6]  = mk(0,1,1,0,0,          32'h22222222,32'hC,        32'h8,       32'h22222222, 1, 0, 0);
    tbl[7]  = mk(0,1,1,0,0,          32'h33333333,32'h10,       32'hC,       32'h33333333, 1, 0, 0);
    tbl[8]  = mk(0,0,0,0,0,          32'h44444444,32'h10,       32'hC,       32'h33333333, 1, 1, 0);
    tbl[9]  = mk(0,1,1,0,0,          32'h44444444,32'h14,       32'h10,      32'h44444444, 1, 1, 0);
    tbl[10] = mk(0,1,1,0,0,          32'h55555555,32'h18,       32'h14,      32'h55555555, 1, 1, 0);
    tbl[11] = mk(0,1,1,0,0,          32'h66666666,32'h1C,       32'h18,      32'h66666666, 1, 1, 0);
    tbl[12] = mk(0,1,1,0,0,          32'h77777777,32'h20,       32'h1C,      32'h77777777, 1, 1, 0);
    tbl[13] = mk(0,1,1,1,32'h100,    32'h88888888,32'h100,      0,           NOP,          0, 1, 1);
    tbl[14] = mk(0,1,1,0,0,          32'h99999999,32'h104,      32'h100,     32'h99999999, 1, 1, 1);
    tbl[15] = mk(0,1,0,0,0,          32'hAAAAAAAA,32'h108,      32'h100,     32'h99999999, 1, 1, 1);
    tbl[16] = mk(0,0,1,0,0,          32'hBBBBBBBB,32'h108,      32'h108,     32'hBBBBBBBB, 1, 2, 1);
    tbl[17] = mk(0,0,0,1,32'h40,     32'hCCCCCCCC,32'h40,       0,           NOP,          0, 2, 2);
    tbl[18] = mk(0,1,1,1,32'hFFFFFFFC,32'hDDDDDDDD,32'hFFFFFFFC,0,           NOP,          0, 2, 3);
    tbl[19] = mk(0,1,1,0,0,          32'hEEEEEEEE,32'h0,        32'hFFFFFFFC,32'hEEEEEEEE, 1, 2, 3);

    drive(0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    #12;
    check_all("reset", 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].pcw, tbl[i].ifw, tbl[i].flush, tbl[i].target, tbl[i].instr);
      @(posedge clk_i); #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ifpc, tbl[i].e_instr,
                tbl[i].e_valid, tbl[i].e_stall, tbl[i].e_flush);
    end

    // async reset while stalled, between edges
    drive(0, 0, 0, 0, 0, 32'h12345678);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    // back in IDLE: enables and flush ignored
    drive(0, 1, 1, 1, 32'h200, 32'h12345678);
    @(posedge clk_i); #1;
    check_all("idle_after_rst", 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);

    m_run = 0; m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0;
    m_stall = 0; m_flush = 0;
    for (int n = 0; n < 400; n++) begin
      logic s, pw, iw, fl;
      logic [31:0] tg, in;
      s  = (n == 2) ? 1'b1 : ($urandom_range(0, 15) == 0);
      pw = $urandom_range(0, 3) != 0;
      iw = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 7) == 0;
      tg = $urandom;
      if ($urandom_range(0, 9) == 0) tg = 32'hFFFF_FFF8;
      in = $urandom;
      drive(s, pw, iw, fl, tg, in);
      if (!m_run) begin
        if (s) m_run = 1;
      end else if (fl) begin
        m_pc = tg; m_ifpc = 0; m_instr = NOP; m_valid = 0;
        m_flush++;
      end else begin
        if (iw) begin m_ifpc = m_pc; m_instr = in; m_valid = 1; end
        if (pw) m_pc = m_pc + 32'd4;
        else    m_stall++;
      end
      @(posedge clk_i); #1;
      check_all($sformatf("rnd%0d", n), m_pc, m_ifpc, m_instr, m_valid,
                PERF ? sat(m_stall) : 32'd0, PERF ? sat(m_flush) : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
